// File: rtl/cic_decim_ctrl.sv
// Run-time controller for a CIC decimator: holds the active ratio, generates the
// decimation strobe and sequences ratio changes (boundary wait, integrator clear, comb settle).
module cic_decim_ctrl #(
  parameter int R_MAX         = 64,
  parameter int R_W           = 7,
  parameter int SETTLE_DECIMS = 4
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic [R_W-1:0] cfg_r_i,
  input  logic           cfg_valid_i,
  output logic           cfg_ready_o,
  output logic           cfg_err_o,
  input  logic           inp_samp_str_i,
  output logic           dec_str_o,
  output logic           out_valid_o,
  output logic           integ_clr_o,
  output logic [R_W-1:0] cur_r_o,
  output logic           busy_o
);

  localparam int S_W = (SETTLE_DECIMS < 2) ? 1 : $clog2(SETTLE_DECIMS + 1);

  typedef enum logic [2:0] {
    S_UNCFG,
    S_RUN,
    S_RECONF,
    S_CLEAR,
    S_SETTLE
  } state_t;

  state_t         state_q, state_d;
  logic [R_W-1:0] cur_r_q, cur_r_d;
  logic [R_W-1:0] pend_r_q, pend_r_d;
  logic [R_W-1:0] phase_q, phase_d;
  logic [S_W-1:0] settle_q, settle_d;
  logic           dec_str_q, dec_str_d;
  logic           out_valid_q, out_valid_d;
  logic           cfg_err_q, cfg_err_d;

  logic accept, legal, counting, bnd;

  assign cfg_ready_o = (state_q == S_UNCFG) || (state_q == S_RUN);
  assign accept      = cfg_valid_i && cfg_ready_o;
  assign legal       = (cfg_r_i >= R_W'(2)) && (cfg_r_i <= R_W'(R_MAX));
  // The phase counter is frozen in UNCFG and CLEAR, so strobes there are dropped.
  assign counting    = (state_q == S_RUN) || (state_q == S_RECONF) || (state_q == S_SETTLE);
  assign bnd         = counting && inp_samp_str_i && (phase_q == cur_r_q - R_W'(1));

  always_comb begin
    state_d     = state_q;
    cur_r_d     = cur_r_q;
    pend_r_d    = pend_r_q;
    phase_d     = phase_q;
    settle_d    = settle_q;
    cfg_err_d   = accept && !legal;
    dec_str_d   = bnd;
    out_valid_d = bnd && ((state_q == S_RUN) || (state_q == S_RECONF));

    if (counting && inp_samp_str_i) begin
      phase_d = bnd ? '0 : phase_q + R_W'(1);
    end

    case (state_q)
      S_UNCFG: begin
        if (accept && legal) begin
          cur_r_d = cfg_r_i;
          state_d = S_CLEAR;
        end
      end
      S_RUN: begin
        if (accept && legal) begin
          if (bnd) begin
            cur_r_d = cfg_r_i;
            state_d = S_CLEAR;
          end else begin
            pend_r_d = cfg_r_i;
            state_d  = S_RECONF;
          end
        end
      end
      S_RECONF: begin
        if (bnd) begin
          cur_r_d = pend_r_q;
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        settle_d = S_W'(SETTLE_DECIMS);
        state_d  = (SETTLE_DECIMS == 0) ? S_RUN : S_SETTLE;
      end
      S_SETTLE: begin
        if (bnd) begin
          settle_d = settle_q - S_W'(1);
          if (settle_q == S_W'(1)) state_d = S_RUN;
        end
      end
      default: state_d = S_UNCFG;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_UNCFG;
      cur_r_q     <= '0;
      pend_r_q    <= '0;
      phase_q     <= '0;
      settle_q    <= '0;
      dec_str_q   <= 1'b0;
      out_valid_q <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_r_q     <= cur_r_d;
      pend_r_q    <= pend_r_d;
      phase_q     <= phase_d;
      settle_q    <= settle_d;
      dec_str_q   <= dec_str_d;
      out_valid_q <= out_valid_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  assign dec_str_o   = dec_str_q;
  assign out_valid_o = out_valid_q;
  assign cfg_err_o   = cfg_err_q;
  assign integ_clr_o = (state_q == S_CLEAR);
  assign busy_o      = (state_q != S_RUN);
  assign cur_r_o     = cur_r_q;

endmodule
